// File: rtl/shift_seq.sv
// ----------------------------------------------------------------------------
// shift_seq
//   Handshaked sequencer for an external combinational 8-bit barrel shifter.
//   It accepts one request and registers its operands onto sh_*. One cycle
//   later it captures the returned sh_dout into out_data and holds the result
//   on a valid/ready output. While the result is being taken it can accept
//   the next request, which gives one result every two cycles.
//
//   Optional feature (macro SHIFT_SEQ_LFSR_EN): an internal 8-bit Fibonacci
//   LFSR, seed 8'h01, that can replace in_din as the operand when in_src = 1.
//   Without the macro the LFSR does not exist and in_src is ignored.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  request handshake
//   in_din, in_shamt   operand, shift amount
//   in_direct, in_type 0 = left / 1 = right, 0 = arithmetic / 1 = logical
//   in_src             0 = in_din, 1 = LFSR (only with SHIFT_SEQ_LFSR_EN)
//   sh_din .. sh_type  registered operands to the barrel shifter
//   sh_dout            result returned by the barrel shifter
//   out_valid/out_ready/out_data  result handshake and captured result
//   done_cnt           count of completed output transfers, wraps at 8 bits
// ----------------------------------------------------------------------------
module shift_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_din,
    input  logic [2:0] in_shamt,
    input  logic       in_direct,
    input  logic       in_type,
    input  logic       in_src,
    output logic [7:0] sh_din,
    output logic [2:0] sh_shamt,
    output logic       sh_direct,
    output logic       sh_type,
    input  logic [7:0] sh_dout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [7:0] done_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_out_xfer;
    logic [7:0] w_operand;

    logic [7:0] r_sh_din;
    logic [2:0] r_sh_shamt;
    logic       r_sh_direct;
    logic       r_sh_type;
    logic       r_out_valid;
    logic [7:0] r_out_data;
    logic [7:0] r_done_cnt;

    // ------------------------------------------------------------------------
    // Operand source
    // ------------------------------------------------------------------------
`ifdef SHIFT_SEQ_LFSR_EN
    logic [7:0] r_lfsr;

    assign w_operand = in_src ? r_lfsr : in_din;

    // Advances only when its value is consumed by an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 8'h01;
        end else if (w_accept && in_src) begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end
`else
    logic w_unused_src;

    assign w_unused_src = in_src;
    assign w_operand    = in_din;
`endif

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                w_state_nxt = HOLD;
            end
            HOLD: begin
                // Taking the result frees the slot, so a new request can be
                // accepted on the same edge.
                w_in_ready = out_ready;
                if (out_ready) w_state_nxt = in_valid ? ISSUE : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_accept   = in_valid && w_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_din    <= '0;
            r_sh_shamt  <= '0;
            r_sh_direct <= 1'b0;
            r_sh_type   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_done_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_sh_din    <= w_operand;
                r_sh_shamt  <= in_shamt;
                r_sh_direct <= in_direct;
                r_sh_type   <= in_type;
            end
            if (r_state == ISSUE) begin
                r_out_data <= sh_dout;
            end
            // out_valid is a registered copy of "state is HOLD".
            r_out_valid <= (w_state_nxt == HOLD);
            if (w_out_xfer) begin
                r_done_cnt <= r_done_cnt + 8'd1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign sh_din    = r_sh_din;
    assign sh_shamt  = r_sh_shamt;
    assign sh_direct = r_sh_direct;
    assign sh_type   = r_sh_type;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_shift_seq.sv
// ----------------------------------------------------------------------------
// tb_shift_seq
//   Bench for shift_seq. A reference barrel shifter closes the sh_* loop.
//   Stimulus pushes hand-computed expected results into a queue when a
//   request is accepted; a monitor pops and compares on every output
//   transfer. Define SHIFT_SEQ_LFSR_EN for both files to exercise the LFSR.
// ----------------------------------------------------------------------------
module tb_shift_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_din;
    logic [2:0] in_shamt;
    logic       in_direct;
    logic       in_type;
    logic       in_src;
    logic [7:0] sh_din;
    logic [2:0] sh_shamt;
    logic       sh_direct;
    logic       sh_type;
    logic [7:0] sh_dout;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] done_cnt;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         t_last   = 0;
    int         t_prev   = 0;
    logic [7:0] exp_q[$];

    shift_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_din    (in_din),
        .in_shamt  (in_shamt),
        .in_direct (in_direct),
        .in_type   (in_type),
        .in_src    (in_src),
        .sh_din    (sh_din),
        .sh_shamt  (sh_shamt),
        .sh_direct (sh_direct),
        .sh_type   (sh_type),
        .sh_dout   (sh_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference barrel shifter: left shifts fill with zero for both types,
    // right arithmetic replicates bit 7.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s,
                                             input logic dir, input logic typ);
        logic [7:0] r;
        if (!dir)     r = d << s;
        else if (typ) r = d >> s;
        else          r = 8'($signed(d) >>> s);
        return r;
    endfunction

    always_comb sh_dout = ref_shift(sh_din, sh_shamt, sh_direct, sh_type);

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge when both are high.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected no output (cycle %0d)", out_data, cyc);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
            t_prev = t_last;
            t_last = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #3;
        exp_q.delete();
        #4;
        rst_n = 1'b1;
        tick();
    endtask

    // Present a request and hold it until accepted; push its expected result
    // at the accepting edge. Returns #1 after that edge with in_valid low.
    task automatic send(input logic [7:0] d, input logic [2:0] s, input logic dir,
                        input logic typ, input logic src, input logic [7:0] exp);
        logic was_ready;
        bit   ok = 1'b0;
        in_valid  = 1'b1;
        in_din    = d;
        in_shamt  = s;
        in_direct = dir;
        in_type   = typ;
        in_src    = src;
        for (int i = 0; i < 20; i++) begin
            #0;
            was_ready = in_ready;
            @(posedge clk);
            if (was_ready) begin
                exp_q.push_back(exp);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept of %h", d);
        end
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_din    = '0;
        in_shamt  = '0;
        in_direct = 1'b0;
        in_type   = 1'b0;
        in_src    = 1'b0;
        out_ready = 1'b0;

        // Reset values, checked before any clock edge.
        #1;
        chk("rst_out_valid", {7'd0, out_valid}, 8'h00);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_sh_din", sh_din, 8'h00);
        chk("rst_sh_ctl", {3'd0, sh_shamt, sh_direct, sh_type}, 8'h00);
        chk("rst_done_cnt", done_cnt, 8'h00);
        #6;
        rst_n = 1'b1;
        tick();
        chk("in_ready_after_reset", {7'd0, in_ready}, 8'h01);

        // Single request, latency and result.
        send(8'h96, 3'd2, 1'b1, 1'b0, 1'b0, 8'hE5);
        chk("lat_issue_valid", {7'd0, out_valid}, 8'h00);
        chk("lat_issue_ready", {7'd0, in_ready}, 8'h00);
        tick();
        chk("lat_hold_valid", {7'd0, out_valid}, 8'h01);
        chk("lat_hold_ready", {7'd0, in_ready}, 8'h00);
        out_ready = 1'b1;
        tick();
        tick();
        chk("done_cnt_single", done_cnt, 8'h01);

        // Back-to-back with out_ready held high.
        do_reset();
        out_ready = 1'b1;
        send(8'h96, 3'd2, 1'b1, 1'b1, 1'b0, 8'h25);
        send(8'h96, 3'd3, 1'b0, 1'b0, 1'b0, 8'hB0);
        tick();
        tick();
        tick();
        chk("b2b_spacing", 8'(t_last - t_prev), 8'd2);
        chk("done_cnt_b2b", done_cnt, 8'h02);

        // Backpressure: second request waits while the result is held.
        out_ready = 1'b0;
        send(8'h81, 3'd1, 1'b1, 1'b0, 1'b0, 8'hC0);
        in_valid  = 1'b1;
        in_din    = 8'h0F;
        in_shamt  = 3'd4;
        in_direct = 1'b0;
        in_type   = 1'b1;
        in_src    = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", {7'd0, in_ready}, 8'h00);
            chk("bp_out_data", out_data, 8'hC0);
            chk("bp_sh_din", sh_din, 8'h81);
            tick();
        end
        out_ready = 1'b1;
        #0;
        chk("bp_release_ready", {7'd0, in_ready}, 8'h01);
        @(posedge clk);
        exp_q.push_back(8'hF0);
        #1;
        in_valid = 1'b0;
        chk("bp_second_accept", sh_din, 8'h0F);
        tick();
        tick();
        chk("done_cnt_bp", done_cnt, 8'h04);

        // Operand source.
        do_reset();
        out_ready = 1'b1;
`ifdef SHIFT_SEQ_LFSR_EN
        send(8'hAA, 3'd0, 1'b0, 1'b0, 1'b1, 8'h01);
        send(8'hAA, 3'd0, 1'b0, 1'b0, 1'b1, 8'h02);
        send(8'hAA, 3'd0, 1'b0, 1'b0, 1'b1, 8'h04);
        send(8'hAA, 3'd0, 1'b0, 1'b0, 1'b1, 8'h08);
        send(8'hAA, 3'd0, 1'b0, 1'b0, 1'b1, 8'h11);
        send(8'h5A, 3'd0, 1'b0, 1'b0, 1'b0, 8'h5A);
        send(8'hAA, 3'd0, 1'b0, 1'b0, 1'b1, 8'h23);
`else
        send(8'h3C, 3'd0, 1'b0, 1'b0, 1'b1, 8'h3C);
        send(8'h3C, 3'd1, 1'b1, 1'b0, 1'b1, 8'h1E);
`endif
        tick();
        tick();
        tick();

        // Reset pulsed during ISSUE discards the transaction.
        send(8'h96, 3'd2, 1'b1, 1'b0, 1'b0, 8'hE5);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_out_valid", {7'd0, out_valid}, 8'h00);
        chk("mid_rst_out_data", out_data, 8'h00);
        chk("mid_rst_sh_din", sh_din, 8'h00);
        chk("mid_rst_sh_ctl", {3'd0, sh_shamt, sh_direct, sh_type}, 8'h00);
        chk("mid_rst_done_cnt", done_cnt, 8'h00);
        #2;
        rst_n = 1'b1;
        tick();
        chk("mid_rst_in_ready", {7'd0, in_ready}, 8'h01);
        for (int i = 0; i < 5; i++) tick();
        chk("mid_rst_no_valid", {7'd0, out_valid}, 8'h00);
        chk("mid_rst_done_after", done_cnt, 8'h00);

        // 256 transfers wrap the counter.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send(8'(i), 3'd0, 1'b0, 1'b1, 1'b0, 8'(i));
        end
        tick();
        tick();
        tick();
        chk("done_cnt_wrap", done_cnt, 8'h00);
        chk("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
